display_source_sequencer: RTL and testbench
===========================================

DISPLAY_SOURCE_SEQUENCER -- requirements
Module: display_source_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 24, dwell counter width in bits.
REQ-002 SHALL have parameter BLANK_CYC, default 16, blanking gap length in clk cycles (used only with blanking compiled in).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port address  input  2  Avalon-MM slave register select.
REQ-006 SHALL have ports write  input  1, read  input  1, and writedata  input  32, the Avalon-MM strobes and write data.
REQ-007 SHALL have port readdata  output  32  registered read data.
REQ-008 SHALL have ports in_a  input  3 and in_b  input  3, the RGB source inputs.
REQ-009 SHALL have port out  output  3  selected (or blanked) RGB.
REQ-010 SHALL have port sel  output  1  current source, 0 = in_a, 1 = in_b.
REQ-011 SHALL have port swap  output  1  one-cycle pulse on every automatic source change.

Function
REQ-012 Register map SHALL be: 0 CTRL (bit0 AUTO, bit1 MAN_SEL), 1 DWELL_A [CNT_W-1:0], 2 DWELL_B [CNT_W-1:0], 3 STATUS (read-only: [1:0] state code, [2] sel, [3] AUTO).
REQ-013 Write SHALL update the addressed register on the clk edge with write=1; writes to STATUS SHALL be ignored.
REQ-014 Read SHALL return data in readdata one cycle after read=1; unused bits read 0; readdata SHALL hold its value while read=0.
REQ-015 FSM states SHALL be MANUAL (code 0), SHOW_A (1), SHOW_B (2), BLANK (3).
REQ-016 In MANUAL: sel = MAN_SEL, out = sel ? in_b : in_a; the transition to SHOW_A SHALL occur on the cycle after AUTO is written to 1, loading the counter from DWELL_A.
REQ-017 In SHOW_A/SHOW_B: the FSM SHALL remain for exactly max(DWELL_x,1) cycles, then advance to the other SHOW state (or BLANK, see REQ-024).
REQ-018 The dwell value SHALL be sampled at state entry; DWELL writes during a dwell SHALL take effect at the next entry.
REQ-019 swap SHALL pulse high for the first cycle of each SHOW state entered from another SHOW state or BLANK, never on entry from MANUAL.
REQ-020 AUTO written 0 in any state SHALL force MANUAL on the next cycle, aborting the dwell; swap SHALL stay low.
REQ-021 out SHALL be combinational from in_a/in_b/sel, except that in BLANK it SHALL be 3'b000.

Reset
REQ-022 Reset asserted SHALL immediately force state MANUAL, CTRL=0, DWELL_A=DWELL_B=0, counter 0, sel=0, swap=0, readdata=0, out=in_a.
REQ-023 Reset deasserted mid-dwell SHALL resume from MANUAL; no partial-dwell state SHALL survive.

Configuration
REQ-024 With SEQ_BLANK_EN defined: each SHOW-to-SHOW transition SHALL pass through BLANK for exactly BLANK_CYC cycles (0 treated as 1); sel SHALL hold the old value during BLANK and change on entry to the next SHOW state.
REQ-025 Without SEQ_BLANK_EN: BLANK SHALL be unreachable, SHOW states SHALL alternate directly, and BLANK_CYC SHALL be ignored.

Structure
REQ-026 State encoding, register address constants and CTRL bit indices SHALL live in shared package display_pkg.
REQ-027 The dwell/blank down-counter SHALL be a sub-module dwell_counter (load, value, done) reused for both dwell and blank timing.

Verification
REQ-028 Reset mid-SHOW_B with AUTO=1 -> state code 0, sel=0, out=in_a, swap=0 on the same cycle as reset assertion.
REQ-029 DWELL_A=3, DWELL_B=5, AUTO=1, no blanking -> sel low 3 cycles, high 5, low 3; swap pulses at each change; out follows in_a=3'b001 / in_b=3'b110.
REQ-030 DWELL_A=0, DWELL_B=0 -> sel toggles every cycle with a swap pulse each cycle.
REQ-031 SEQ_BLANK_EN, BLANK_CYC=4, DWELL_A=DWELL_B=2 -> pattern A,A,0,0,0,0,B,B,0,0,0,0,A; STATUS reads 3 during the gap.
REQ-032 AUTO cleared while 2 cycles into a 10-cycle DWELL_B with MAN_SEL=0 -> next cycle state 0, sel=0, no swap.
REQ-033 DWELL_A rewritten from 8 to 2 mid SHOW_A -> current dwell still 8 cycles; next SHOW_A lasts 2 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display source sequencer: FSM state codes,
// register addresses and CTRL bit positions.
package display_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SHOW_A = 2'd1,
        ST_SHOW_B = 2'd2,
        ST_BLANK  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_DWELL_A = 2'd1;
    localparam logic [1:0] ADDR_DWELL_B = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_AUTO_BIT    = 0;
    localparam int CTRL_MAN_SEL_BIT = 1;

    function automatic logic is_show(state_e s);
        return (s == ST_SHOW_A) || (s == ST_SHOW_B);
    endfunction

endpackage

// File: rtl/display_source_sequencer_if.sv
// Avalon-MM register port of the display source sequencer.
interface display_source_sequencer_if;

    logic [1:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, write, read, writedata, input readdata);
    modport slave  (input address, write, read, writedata, output readdata);

endinterface

// File: rtl/display_source_sequencer_dwell_counter.sv
// Loadable down-counter that times both the dwell and the blanking gap.
// A load of N yields done after max(N,1) cycles in the loaded state.
module dwell_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // NOTE: value_d is given a default before any branch so no latch is inferred.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (load_val == '0) ? '0 : load_val - CNT_W'(1);
        end else if (value_q != '0) begin
            value_d = value_q - CNT_W'(1);
        end
    end

    // NOTE: flops use <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;
    assign done  = (value_q == '0);

endmodule

// File: rtl/display_source_sequencer.sv
// Alternates the RGB output between two sources with programmable dwell times.
// Define SEQ_BLANK_EN to insert a BLANK_CYC-cycle black gap between sources.
module display_source_sequencer
    import display_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int BLANK_CYC = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    display_source_sequencer_if.slave   avs,
    input  logic [2:0]                  in_a,
    input  logic [2:0]                  in_b,
    output logic [2:0]                  out,
    output logic                        sel,
    output logic                        swap
);

`ifdef SEQ_BLANK_EN
    localparam state_e AFTER_A = ST_BLANK;
    localparam state_e AFTER_B = ST_BLANK;
`else
    localparam state_e AFTER_A = ST_SHOW_B;
    localparam state_e AFTER_B = ST_SHOW_A;
`endif

    logic [1:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] dwell_a_q, dwell_a_d;
    logic [CNT_W-1:0] dwell_b_q, dwell_b_d;
    logic [31:0]      readdata_q, readdata_d;
    state_e           state_q, state_d;
    logic             from_b_q, from_b_d;
    logic             swap_q, swap_d;

    logic             auto_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;
    logic             sel_c;
    logic             blank_c;

    dwell_counter #(.CNT_W(CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .value    (cnt_value),
        .done     (cnt_done)
    );

    // Register file and registered read port.
    always_comb begin
        ctrl_d     = ctrl_q;
        dwell_a_d  = dwell_a_q;
        dwell_b_d  = dwell_b_q;
        readdata_d = readdata_q;
        if (avs.write) begin
            case (avs.address)
                ADDR_CTRL: begin
                    ctrl_d[CTRL_AUTO_BIT]    = avs.writedata[CTRL_AUTO_BIT];
                    ctrl_d[CTRL_MAN_SEL_BIT] = avs.writedata[CTRL_MAN_SEL_BIT];
                end
                ADDR_DWELL_A: dwell_a_d = avs.writedata[CNT_W-1:0];
                ADDR_DWELL_B: dwell_b_d = avs.writedata[CNT_W-1:0];
                default: ;
            endcase
        end
        if (avs.read) begin
            case (avs.address)
                ADDR_CTRL:    readdata_d = {30'd0, ctrl_q};
                ADDR_DWELL_A: readdata_d = 32'(dwell_a_q);
                ADDR_DWELL_B: readdata_d = 32'(dwell_b_q);
                default:      readdata_d = {28'd0, ctrl_q[CTRL_AUTO_BIT], sel_c, state_q};
            endcase
        end
    end

    // AUTO takes effect on the same edge that captures the CTRL write.
    assign auto_d = ctrl_d[CTRL_AUTO_BIT];

    // Next state, counter load and swap pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MANUAL: state_d = ST_SHOW_A;
            ST_SHOW_A: if (cnt_done) state_d = AFTER_A;
            ST_SHOW_B: if (cnt_done) state_d = AFTER_B;
            default:   if (cnt_done) state_d = from_b_q ? ST_SHOW_A : ST_SHOW_B;
        endcase
        if (!auto_d) state_d = ST_MANUAL;

        from_b_d = from_b_q;
        if (state_q == ST_SHOW_A) from_b_d = 1'b0;
        if (state_q == ST_SHOW_B) from_b_d = 1'b1;

        cnt_load = (state_d != state_q);
        case (state_d)
            ST_SHOW_A: cnt_val = dwell_a_q;
            ST_SHOW_B: cnt_val = dwell_b_q;
            ST_BLANK:  cnt_val = CNT_W'(BLANK_CYC);
            default:   cnt_val = '0;
        endcase

        swap_d = is_show(state_d) && (state_q != ST_MANUAL) && (state_d != state_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            dwell_a_q  <= '0;
            dwell_b_q  <= '0;
            readdata_q <= '0;
            state_q    <= ST_MANUAL;
            from_b_q   <= 1'b0;
            swap_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            dwell_a_q  <= dwell_a_d;
            dwell_b_q  <= dwell_b_d;
            readdata_q <= readdata_d;
            state_q    <= state_d;
            from_b_q   <= from_b_d;
            swap_q     <= swap_d;
        end
    end

    // Outputs decoded from the current state; BLANK keeps the previous source.
    always_comb begin
        sel_c   = 1'b0;
        blank_c = 1'b0;
        case (state_q)
            ST_MANUAL: sel_c = ctrl_q[CTRL_MAN_SEL_BIT];
            ST_SHOW_A: sel_c = 1'b0;
            ST_SHOW_B: sel_c = 1'b1;
            default: begin
                sel_c   = from_b_q;
                blank_c = 1'b1;
            end
        endcase
    end

    assign out          = blank_c ? 3'b000 : (sel_c ? in_b : in_a);
    assign sel          = sel_c;
    assign swap         = swap_q;
    assign avs.readdata = readdata_q;

    // Bits not consumed by the register file or the FSM.
    logic unused_bits;
    assign unused_bits = ^{cnt_value, avs.writedata};

endmodule

// File: tb/tb_display_source_sequencer.sv
// Directed self-checking bench for display_source_sequencer.
module tb_display_source_sequencer;
    import display_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] in_a, in_b, out;
    logic       sel, swap;
    int         checks = 0;
    int         errors = 0;

    display_source_sequencer_if avs();

    display_source_sequencer #(.CNT_W(24), .BLANK_CYC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .avs   (avs),
        .in_a  (in_a),
        .in_b  (in_b),
        .out   (out),
        .sel   (sel),
        .swap  (swap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Bus tasks start and end on a falling edge.
    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
        avs.address   = addr;
        avs.writedata = data;
        avs.write     = 1'b1;
        @(negedge clk);
        avs.write     = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
        avs.address = addr;
        avs.read    = 1'b1;
        @(negedge clk);
        avs.read    = 1'b0;
        data        = avs.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        in_a = 3'b011; in_b = 3'b100;
        avs.address = '0; avs.write = 1'b0; avs.read = 1'b0; avs.writedata = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset sel got %b exp 0", sel); end
        checks++; if (swap !== 1'b0) begin errors++; $display("FAIL reset swap got %b exp 0", swap); end
        checks++; if (out !== 3'b011) begin errors++; $display("FAIL reset out got %b exp 011", out); end
        checks++; if (avs.readdata !== 32'd0) begin errors++; $display("FAIL reset readdata got %h exp 0", avs.readdata); end
        reset = 1'b0;
        @(negedge clk);
        read_reg(ADDR_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset status got %h exp 0", rd); end
        read_reg(ADDR_DWELL_A, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset dwell_a got %h exp 0", rd); end
    endtask

    task automatic test_registers();
        logic [31:0] rd;
        write_reg(ADDR_DWELL_A, 32'h0012_3456);
        read_reg(ADDR_DWELL_A, rd);
        checks++; if (rd !== 32'h0012_3456) begin errors++; $display("FAIL reg dwell_a got %h exp 00123456", rd); end
        write_reg(ADDR_DWELL_B, 32'hFFAB_CDEF);
        read_reg(ADDR_DWELL_B, rd);
        checks++; if (rd !== 32'h00AB_CDEF) begin errors++; $display("FAIL reg dwell_b got %h exp 00abcdef", rd); end
        write_reg(ADDR_CTRL, 32'hFFFF_FFFE);
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL manual sel got %b exp 1", sel); end
        checks++; if (out !== 3'b100) begin errors++; $display("FAIL manual out got %b exp 100", out); end
        read_reg(ADDR_CTRL, rd);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL reg ctrl got %h exp 2", rd); end
        read_reg(ADDR_STATUS, rd);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL manual status got %h exp 4", rd); end
        write_reg(ADDR_STATUS, 32'hFFFF_FFFF);
        read_reg(ADDR_STATUS, rd);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL status write ignored got %h exp 4", rd); end
        repeat (3) @(negedge clk);
        checks++; if (avs.readdata !== 32'd4) begin errors++; $display("FAIL readdata hold got %h exp 4", avs.readdata); end
        write_reg(ADDR_CTRL, 32'd0);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL manual sel back got %b exp 0", sel); end
    endtask

    task automatic test_auto_dwell();
        logic [31:0] rd;
        logic        exp_sel, exp_swap;
        in_a = 3'b001; in_b = 3'b110;
        write_reg(ADDR_DWELL_A, 32'd3);
        write_reg(ADDR_DWELL_B, 32'd5);
        write_reg(ADDR_CTRL, 32'd1);
        for (int k = 0; k <= 10; k++) begin
            exp_sel  = (k >= 3 && k < 8);
            exp_swap = (k == 3 || k == 8);
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL dwell sel k=%0d got %b exp %b", k, sel, exp_sel); end
            checks++; if (swap !== exp_swap) begin errors++; $display("FAIL dwell swap k=%0d got %b exp %b", k, swap, exp_swap); end
            checks++; if (out !== (exp_sel ? 3'b110 : 3'b001)) begin errors++; $display("FAIL dwell out k=%0d got %b", k, out); end
            @(negedge clk);
        end
        read_reg(ADDR_STATUS, rd);
        checks++; if (rd !== 32'd14) begin errors++; $display("FAIL dwell status got %h exp e", rd); end
        write_reg(ADDR_CTRL, 32'd0);
        checks++; if (sel !== 1'b0 || swap !== 1'b0) begin errors++; $display("FAIL dwell stop sel=%b swap=%b exp 0 0", sel, swap); end
    endtask

    task automatic test_zero_dwell();
        logic exp_sel, exp_swap;
        write_reg(ADDR_DWELL_A, 32'd0);
        write_reg(ADDR_DWELL_B, 32'd0);
        write_reg(ADDR_CTRL, 32'd1);
        for (int k = 0; k <= 5; k++) begin
            exp_sel  = k[0];
            exp_swap = (k > 0);
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL zero sel k=%0d got %b exp %b", k, sel, exp_sel); end
            checks++; if (swap !== exp_swap) begin errors++; $display("FAIL zero swap k=%0d got %b exp %b", k, swap, exp_swap); end
            @(negedge clk);
        end
        write_reg(ADDR_CTRL, 32'd0);
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        write_reg(ADDR_DWELL_A, 32'd1);
        write_reg(ADDR_DWELL_B, 32'd10);
        write_reg(ADDR_CTRL, 32'd1);
        @(negedge clk);
        checks++; if (sel !== 1'b1 || swap !== 1'b1) begin errors++; $display("FAIL abort enter_b sel=%b swap=%b exp 1 1", sel, swap); end
        @(negedge clk);
        write_reg(ADDR_CTRL, 32'd0);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL abort sel got %b exp 0", sel); end
        checks++; if (swap !== 1'b0) begin errors++; $display("FAIL abort swap got %b exp 0", swap); end
        checks++; if (out !== in_a) begin errors++; $display("FAIL abort out got %b exp %b", out, in_a); end
        read_reg(ADDR_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL abort status got %h exp 0", rd); end
        checks++; if (swap !== 1'b0 || sel !== 1'b0) begin errors++; $display("FAIL abort later sel=%b swap=%b exp 0 0", sel, swap); end
    endtask

    task automatic test_dwell_rewrite();
        logic exp_sel, exp_swap;
        write_reg(ADDR_DWELL_A, 32'd8);
        write_reg(ADDR_DWELL_B, 32'd1);
        write_reg(ADDR_CTRL, 32'd1);
        for (int k = 0; k <= 11; k++) begin
            exp_sel  = (k == 8 || k == 11);
            exp_swap = (k == 8 || k == 9 || k == 11);
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL rewrite sel k=%0d got %b exp %b", k, sel, exp_sel); end
            checks++; if (swap !== exp_swap) begin errors++; $display("FAIL rewrite swap k=%0d got %b exp %b", k, swap, exp_swap); end
            if (k == 2) begin
                avs.address = ADDR_DWELL_A; avs.writedata = 32'd2; avs.write = 1'b1;
            end
            @(negedge clk);
            avs.write = 1'b0;
        end
        write_reg(ADDR_CTRL, 32'd0);
    endtask

    task automatic test_reset_mid_show();
        logic [31:0] rd;
        in_a = 3'b101; in_b = 3'b010;
        write_reg(ADDR_DWELL_A, 32'd1);
        write_reg(ADDR_DWELL_B, 32'd10);
        read_reg(ADDR_DWELL_B, rd);
        checks++; if (rd !== 32'd10) begin errors++; $display("FAIL midreset dwell_b got %h exp a", rd); end
        write_reg(ADDR_CTRL, 32'd1);
        @(negedge clk);
        checks++; if (sel !== 1'b1 || swap !== 1'b1 || out !== 3'b010) begin
            errors++; $display("FAIL midreset show_b sel=%b swap=%b out=%b exp 1 1 010", sel, swap, out);
        end
        reset = 1'b1;
        #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL midreset sel got %b exp 0", sel); end
        checks++; if (swap !== 1'b0) begin errors++; $display("FAIL midreset swap got %b exp 0", swap); end
        checks++; if (out !== 3'b101) begin errors++; $display("FAIL midreset out got %b exp 101", out); end
        checks++; if (avs.readdata !== 32'd0) begin errors++; $display("FAIL midreset readdata got %h exp 0", avs.readdata); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sel !== 1'b0 || swap !== 1'b0) begin errors++; $display("FAIL postreset sel=%b swap=%b exp 0 0", sel, swap); end
        read_reg(ADDR_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL postreset status got %h exp 0", rd); end
        read_reg(ADDR_DWELL_B, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL postreset dwell_b got %h exp 0", rd); end
    endtask

    task automatic test_blank();
        logic [2:0] exp_out;
        logic       exp_sel, exp_swap;
        in_a = 3'b001; in_b = 3'b110;
        write_reg(ADDR_DWELL_A, 32'd2);
        write_reg(ADDR_DWELL_B, 32'd2);
        write_reg(ADDR_CTRL, 32'd1);
        for (int k = 0; k <= 12; k++) begin
            exp_sel  = (k >= 6 && k < 12);
            exp_swap = (k == 6 || k == 12);
            if (k < 2 || k == 12)  exp_out = 3'b001;
            else if (k == 6 || k == 7) exp_out = 3'b110;
            else                   exp_out = 3'b000;
            checks++; if (out !== exp_out) begin errors++; $display("FAIL blank out k=%0d got %b exp %b", k, out, exp_out); end
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL blank sel k=%0d got %b exp %b", k, sel, exp_sel); end
            checks++; if (swap !== exp_swap) begin errors++; $display("FAIL blank swap k=%0d got %b exp %b", k, swap, exp_swap); end
            if (k == 3 || k == 9) begin
                avs.address = ADDR_STATUS; avs.read = 1'b1;
            end
            @(negedge clk);
            avs.read = 1'b0;
            if (k == 3) begin
                checks++; if (avs.readdata !== 32'd11) begin errors++; $display("FAIL blank status a got %h exp b", avs.readdata); end
            end
            if (k == 9) begin
                checks++; if (avs.readdata !== 32'd15) begin errors++; $display("FAIL blank status b got %h exp f", avs.readdata); end
            end
        end
        write_reg(ADDR_CTRL, 32'd0);
    endtask

    initial begin
        test_reset();
        test_registers();
`ifdef SEQ_BLANK_EN
        test_blank();
`else
        test_auto_dwell();
        test_zero_dwell();
        test_abort();
        test_dwell_rewrite();
        test_reset_mid_show();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
